// File: rtl/xm_mem_controller.sv
// XM CPU bus-master memory controller: turns one datapath request into one classic
// Wishbone-style bus cycle, with misaligned-word and bus-timeout error reporting.
//
// state | meaning
// IDLE  | waiting for memEn_i; request fields latched on accept
// BUS   | cyc_o/stb_o asserted, waiting for ack_i or timeout
// DONE  | one-cycle completion pulse
// ERR   | one-cycle completion + badMem pulse (misaligned or timeout)
module xm_mem_controller #(
    parameter int WORD    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            memEn_i,
    input  logic            memWr_i,
    input  logic            byteOp_i,
    input  logic [WORD-1:0] memAdr_i,
    input  logic [WORD-1:0] memDat_i,
    output logic [WORD-1:0] memDat_o,
    output logic            memBusy_o,
    output logic            memDone_o,
    output logic            badMem_o,
    input  logic            ack_i,
    input  logic [WORD-1:0] dat_i,
    output logic            we_o,
    output logic            stb_o,
    output logic            cyc_o,
    output logic [1:0]      sel_o,
    output logic [WORD-1:0] adr_o,
    output logic [WORD-1:0] dat_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;

    state_t        state;
    state_t        stateNext;
    logic [CW-1:0] timer;
    logic          byteQ;
    logic          laneHiQ;
    logic [7:0]    lane;
    logic          misaligned;
    logic          timerEnd;

    assign misaligned = !byteOp_i && memAdr_i[0];
    assign timerEnd   = (timer == CW'(TIMEOUT - 1));
    assign lane       = laneHiQ ? dat_i[15:8] : dat_i[7:0];

    always_ff @(posedge clk_i) begin
        if (arst_i) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (memEn_i) stateNext = misaligned ? ERR : BUS;
            BUS: begin
                if (ack_i)         stateNext = DONE;
                else if (timerEnd) stateNext = ERR;
            end
            DONE:    stateNext = IDLE;
            ERR:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Bus fields are loaded once on accept, so they cannot move during BUS.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            timer    <= '0;
            byteQ    <= 1'b0;
            laneHiQ  <= 1'b0;
            we_o     <= 1'b0;
            sel_o    <= 2'b00;
            adr_o    <= '0;
            dat_o    <= '0;
            memDat_o <= '0;
        end else if (state == IDLE) begin
            if (memEn_i) begin
                timer   <= '0;
                byteQ   <= byteOp_i;
                laneHiQ <= memAdr_i[0];
                we_o    <= memWr_i;
                adr_o   <= {memAdr_i[WORD-1:1], 1'b0};
                if (byteOp_i) begin
                    sel_o <= memAdr_i[0] ? 2'b10 : 2'b01;
                    dat_o <= {(WORD/8){memDat_i[7:0]}};
                end else begin
                    sel_o <= 2'b11;
                    dat_o <= memDat_i;
                end
            end
        end else if (state == BUS) begin
            if (ack_i) begin
                if (!we_o) memDat_o <= byteQ ? {{(WORD-8){1'b0}}, lane} : dat_i;
            end else begin
                timer <= timer + CW'(1);
            end
        end
    end

    assign cyc_o     = (state == BUS);
    assign stb_o     = (state == BUS);
    assign memBusy_o = (state != IDLE);
    assign memDone_o = (state == DONE) || (state == ERR);
    assign badMem_o  = (state == ERR);

endmodule

// File: tb/tb_xm_mem_controller.sv
// Directed self-checking bench for xm_mem_controller (WORD=16, TIMEOUT=15).
module tb_xm_mem_controller;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        memEn_i;
    logic        memWr_i;
    logic        byteOp_i;
    logic [15:0] memAdr_i;
    logic [15:0] memDat_i;
    logic [15:0] memDat_o;
    logic        memBusy_o;
    logic        memDone_o;
    logic        badMem_o;
    logic        ack_i;
    logic [15:0] dat_i;
    logic        we_o;
    logic        stb_o;
    logic        cyc_o;
    logic [1:0]  sel_o;
    logic [15:0] adr_o;
    logic [15:0] dat_o;

    int nCmp = 0;
    int nBad = 0;

    xm_mem_controller #(.WORD(16), .TIMEOUT(15)) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .memEn_i(memEn_i), .memWr_i(memWr_i), .byteOp_i(byteOp_i),
        .memAdr_i(memAdr_i), .memDat_i(memDat_i), .memDat_o(memDat_o),
        .memBusy_o(memBusy_o), .memDone_o(memDone_o), .badMem_o(badMem_o),
        .ack_i(ack_i), .dat_i(dat_i),
        .we_o(we_o), .stb_o(stb_o), .cyc_o(cyc_o),
        .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic wr, input logic bop, input logic [15:0] adr,
                           input logic [15:0] dat);
        memEn_i  = 1'b1;
        memWr_i  = wr;
        byteOp_i = bop;
        memAdr_i = adr;
        memDat_i = dat;
    endtask

    initial begin
        int cycles;
        int doneSeen;

        arst_i = 1'b1; memEn_i = 1'b0; memWr_i = 1'b0; byteOp_i = 1'b0;
        memAdr_i = '0; memDat_i = '0; ack_i = 1'b0; dat_i = '0;
        tick(); tick();
        arst_i = 1'b0;
        chk("rst_busy", memBusy_o, 0);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_done", memDone_o, 0);
        chk("rst_sel", sel_o, 0);
        chk("rst_adr", adr_o, 0);
        chk("rst_memdat", memDat_o, 0);

        // word read, ack on third BUS cycle
        request(1'b0, 1'b0, 16'h1234, 16'h0000);
        tick();
        memEn_i = 1'b0;
        chk("wr_cyc1", cyc_o, 1);
        chk("wr_stb1", stb_o, 1);
        chk("wr_busy1", memBusy_o, 1);
        chk("wr_adr", adr_o, 16'h1234);
        chk("wr_sel", sel_o, 2'b11);
        chk("wr_we", we_o, 0);
        tick();
        chk("wr_cyc2", cyc_o, 1);
        tick();
        chk("wr_cyc3", cyc_o, 1);
        ack_i = 1'b1; dat_i = 16'hBEEF;
        tick();
        ack_i = 1'b0; dat_i = 16'h0000;
        chk("wr_cyc_off", cyc_o, 0);
        chk("wr_done", memDone_o, 1);
        chk("wr_bad", badMem_o, 0);
        chk("wr_memdat", memDat_o, 16'hBEEF);
        tick();
        chk("wr_idle_busy", memBusy_o, 0);
        chk("wr_idle_done", memDone_o, 0);

        // byte write to odd address, immediate ack
        request(1'b1, 1'b1, 16'h0101, 16'h55AA);
        tick();
        memEn_i = 1'b0;
        ack_i = 1'b1; dat_i = 16'h1111;
        chk("bw_adr", adr_o, 16'h0100);
        chk("bw_sel", sel_o, 2'b10);
        chk("bw_dat", dat_o, 16'hAAAA);
        chk("bw_we", we_o, 1);
        chk("bw_cyc", cyc_o, 1);
        tick();
        ack_i = 1'b0;
        chk("bw_done", memDone_o, 1);
        chk("bw_bad", badMem_o, 0);
        chk("bw_memdat_kept", memDat_o, 16'hBEEF);
        // request held during DONE must be ignored, then taken at the next IDLE edge
        request(1'b0, 1'b1, 16'h0100, 16'h0000);
        tick();
        chk("br_wait_busy", memBusy_o, 0);
        chk("br_wait_cyc", cyc_o, 0);
        tick();
        memEn_i = 1'b0;
        chk("br_cyc", cyc_o, 1);
        chk("br_sel", sel_o, 2'b01);
        chk("br_we", we_o, 0);
        ack_i = 1'b1; dat_i = 16'hC3D4;
        tick();
        ack_i = 1'b0; dat_i = 16'h0000;
        chk("br_done", memDone_o, 1);
        chk("br_memdat", memDat_o, 16'h00D4);
        tick();

        // misaligned word write
        request(1'b1, 1'b0, 16'h0003, 16'h7777);
        tick();
        chk("mis_cyc", cyc_o, 0);
        chk("mis_done", memDone_o, 1);
        chk("mis_bad", badMem_o, 1);
        chk("mis_memdat", memDat_o, 16'h00D4);
        request(1'b0, 1'b0, 16'h0200, 16'h0000);
        tick();
        chk("mis_idle_busy", memBusy_o, 0);
        chk("mis_idle_cyc", cyc_o, 0);
        tick();
        memEn_i = 1'b0;

        // timeout: the request above is never acked; stray memEn pulses during BUS
        cycles = 0;
        while (cyc_o && cycles < 40) begin
            cycles++;
            if (adr_o !== 16'h0200) chk("to_adr_stable", adr_o, 16'h0200);
            request(1'b1, 1'b0, 16'h0400 + 16'(cycles), 16'h0000);
            memEn_i = (cycles % 4 == 1) && (cycles < 14);
            tick();
        end
        memEn_i = 1'b0;
        chk("to_cycles", cycles, 15);
        chk("to_done", memDone_o, 1);
        chk("to_bad", badMem_o, 1);
        chk("to_memdat", memDat_o, 16'h00D4);
        tick();
        ack_i = 1'b1; dat_i = 16'hFFFF;
        chk("late_busy0", memBusy_o, 0);
        tick();
        ack_i = 1'b0;
        chk("late_busy", memBusy_o, 0);
        chk("late_done", memDone_o, 0);
        chk("late_cyc", cyc_o, 0);
        chk("late_memdat", memDat_o, 16'h00D4);

        // reset while a bus cycle is in flight
        request(1'b0, 1'b0, 16'h0400, 16'h0000);
        tick();
        memEn_i = 1'b0;
        chk("rb_cyc_before", cyc_o, 1);
        arst_i = 1'b1;
        tick();
        chk("rb_cyc", cyc_o, 0);
        chk("rb_stb", stb_o, 0);
        chk("rb_busy", memBusy_o, 0);
        chk("rb_done", memDone_o, 0);
        chk("rb_memdat", memDat_o, 16'h0000);
        chk("rb_adr", adr_o, 16'h0000);
        tick();
        arst_i = 1'b0;
        ack_i = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (memDone_o || cyc_o) doneSeen++;
        end
        ack_i = 1'b0;
        chk("rb_no_done", doneSeen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
